// File: rtl/tlb_walker.sv
// Two-level page-table walker feeding the TLB fill port.
// Reads the level-1 directory entry, then the level-2 table entry, checks
// presence and user permission, and either writes {pid, vpn} -> frame into
// the TLB or returns a page-fault code. A pipeline abort cancels the walk
// without any visible response; a read still in flight is drained first.
module tlb_walker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_pid,
  input  logic [31:0] req_vaddr,
  input  logic        req_kmode,
  input  logic [17:0] ptbr,
  input  logic        abort,
  output logic        mem_req,
  output logic [17:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [31:0] tlb_key,
  output logic [31:0] tlb_data,
  output logic        resp_valid,
  output logic [7:0]  resp_exc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_L2,
    S_FILL,
    S_FAULT,
    S_DRAIN
  } state_e;

  localparam logic [7:0] EXC_NP_KERNEL = 8'h85;
  localparam logic [7:0] EXC_NP_USER   = 8'h84;
  localparam logic [7:0] EXC_PROT      = 8'h86;

  state_e      state_q, state_d;
  logic [11:0] pid_q, pid_d;
  logic [19:0] vpn_q, vpn_d;
  logic        kmode_q, kmode_d;
  logic [5:0]  ptbr_frame_q, ptbr_frame_d;
  logic [5:0]  pde_frame_q, pde_frame_d;
  logic [7:0]  exc_q, exc_d;
  logic [31:0] tlb_key_q, tlb_key_d;
  logic [31:0] tlb_data_q, tlb_data_d;

  // Address offsets and unused entry fields are deliberately not consumed.
  logic unused_bits;
  assign unused_bits = ^{req_vaddr[11:0], ptbr[11:0], mem_rdata[31:18], mem_rdata[11:2]};

  // Not-present code depends on the privilege of the missing access.
  logic [7:0] np_code;
  assign np_code = kmode_q ? EXC_NP_KERNEL : EXC_NP_USER;

  // Next-state and datapath latching; nothing moves while clk_en is low.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d      = state_q;
    pid_d        = pid_q;
    vpn_d        = vpn_q;
    kmode_d      = kmode_q;
    ptbr_frame_d = ptbr_frame_q;
    pde_frame_d  = pde_frame_q;
    exc_d        = exc_q;
    tlb_key_d    = tlb_key_q;
    tlb_data_d   = tlb_data_q;

    if (clk_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && !abort) begin
            pid_d        = req_pid;
            vpn_d        = req_vaddr[31:12];
            kmode_d      = req_kmode;
            ptbr_frame_d = ptbr[17:12];
            state_d      = S_L1;
          end
        end
        S_L1: begin
          if (abort) begin
            state_d = mem_ack ? S_IDLE : S_DRAIN;
          end else if (mem_ack) begin
            if (!mem_rdata[0]) begin
              exc_d   = np_code;
              state_d = S_FAULT;
            end else begin
              pde_frame_d = mem_rdata[17:12];
              state_d     = S_L2;
            end
          end
        end
        S_L2: begin
          if (abort) begin
            state_d = mem_ack ? S_IDLE : S_DRAIN;
          end else if (mem_ack) begin
            if (!mem_rdata[0]) begin
              exc_d   = np_code;
              state_d = S_FAULT;
            end else if (!kmode_q && !mem_rdata[1]) begin
              exc_d   = EXC_PROT;
              state_d = S_FAULT;
            end else begin
              tlb_key_d  = {pid_q, vpn_q};
              tlb_data_d = {26'b0, mem_rdata[17:12]};
              state_d    = S_FILL;
            end
          end
        end
        S_FILL, S_FAULT: state_d = S_IDLE;
        S_DRAIN: begin
          if (mem_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; pulses are gated by clk_en so a frozen
  // FILL/FAULT cycle cannot repeat its strobe, and by abort to cancel it.
  always_comb begin
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    tlb_we     = 1'b0;
    resp_valid = 1'b0;
    resp_exc   = '0;
    unique case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_L1: begin
        mem_req  = 1'b1;
        mem_addr = {ptbr_frame_q, vpn_q[19:10], 2'b00};
      end
      S_L2: begin
        mem_req  = 1'b1;
        mem_addr = {pde_frame_q, vpn_q[9:0], 2'b00};
      end
      S_FILL: begin
        tlb_we     = clk_en && !abort;
        resp_valid = clk_en && !abort;
      end
      S_FAULT: begin
        resp_valid = clk_en && !abort;
        resp_exc   = exc_q;
      end
      default: ;
    endcase
  end

  assign tlb_key  = tlb_key_q;
  assign tlb_data = tlb_data_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pid_q        <= '0;
      vpn_q        <= '0;
      kmode_q      <= 1'b0;
      ptbr_frame_q <= '0;
      pde_frame_q  <= '0;
      exc_q        <= '0;
      tlb_key_q    <= '0;
      tlb_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      pid_q        <= pid_d;
      vpn_q        <= vpn_d;
      kmode_q      <= kmode_d;
      ptbr_frame_q <= ptbr_frame_d;
      pde_frame_q  <= pde_frame_d;
      exc_q        <= exc_d;
      tlb_key_q    <= tlb_key_d;
      tlb_data_q   <= tlb_data_d;
    end
  end

endmodule
